// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  localparam int unsigned DB_CYCLES_DEF   = 50000;
  localparam int unsigned LONG_CYCLES_DEF = 25000000;

endpackage

// File: rtl/debounce_ch.sv
// Single button channel: two-flop synchroniser, debounce FSM, hold counter and
// registered level/press/release/long outputs.
module debounce_ch
  import key_debouncer_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned LONG_W      = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);

  db_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LONG_W-1:0] hcnt_q, hcnt_d;
  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              p;

  assign p = ~sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser resets to the released level so a held button is re-debounced.
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= sw_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (p) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        // Saturating hold count; the strobe fires on the step into LONG_LAST only.
        if (hcnt_q < LONG_LAST) begin
          hcnt_d = hcnt_q + 1'b1;
          long_d = (hcnt_q == LONG_PRE);
        end
        if (!p) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (p) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debouncer.sv
// Two independent debounced button channels feeding the pulse-divider control FSM.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int unsigned LONG_W      = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_0,
  input  logic sw_1,
  output logic key0_level,
  output logic key1_level,
  output logic key0_press,
  output logic key1_press,
  output logic key0_release,
  output logic key1_release,
  output logic key0_long,
  output logic key1_long
);

  debounce_ch #(
    .DB_CYCLES  (DB_CYCLES),
    .CNT_W      (CNT_W),
    .LONG_CYCLES(LONG_CYCLES),
    .LONG_W     (LONG_W)
  ) u_ch0 (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (sw_0),
    .level_o  (key0_level),
    .press_o  (key0_press),
    .release_o(key0_release),
    .long_o   (key0_long)
  );

  debounce_ch #(
    .DB_CYCLES  (DB_CYCLES),
    .CNT_W      (CNT_W),
    .LONG_CYCLES(LONG_CYCLES),
    .LONG_W     (LONG_W)
  ) u_ch1 (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (sw_1),
    .level_o  (key1_level),
    .press_o  (key1_press),
    .release_o(key1_release),
    .long_o   (key1_long)
  );

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DB_CYCLES=4, LONG_CYCLES=10.
module tb_key_debouncer;

  logic clk, rst, sw_0, sw_1;
  logic key0_level, key1_level, key0_press, key1_press;
  logic key0_release, key1_release, key0_long, key1_long;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sw0;
    logic       sw1;
    logic       rst;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  key_debouncer #(
    .DB_CYCLES  (4),
    .CNT_W      (16),
    .LONG_CYCLES(10),
    .LONG_W     (25)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_0        (sw_0),
    .sw_1        (sw_1),
    .key0_level  (key0_level),
    .key1_level  (key1_level),
    .key0_press  (key0_press),
    .key1_press  (key1_press),
    .key0_release(key0_release),
    .key1_release(key1_release),
    .key0_long   (key0_long),
    .key1_long   (key1_long)
  );

  // Packed as {level0, press0, release0, long0, level1, press1, release1, long1}.
  assign outs = {key0_level, key0_press, key0_release, key0_long,
                 key1_level, key1_press, key1_release, key1_long};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sw_0 = 1'b1;
    sw_1 = 1'b1;
    tick();
    check("reset", 0, outs, 8'h00);
    rst = 1'b0;
  endtask

  function automatic void add(input logic s0, input logic s1, input logic r,
                              input logic [7:0] e);
    vec_t v;
    v.sw0 = s0;
    v.sw1 = s1;
    v.rst = r;
    v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    int longs;
    logic [7:0] e;
    rst  = 1'b1;
    sw_0 = 1'b1;
    sw_1 = 1'b1;

    // Reset state, clean press on ch0, reset while HELD with button held,
    // then simultaneous presses re-debounced from IDLE.
    add(1, 1, 1, 8'h00);
    add(1, 1, 1, 8'h00);
    for (int n = 0; n <= 8; n++)
      add(0, 1, 0, (n == 6) ? 8'hC0 : ((n > 6) ? 8'h80 : 8'h00));
    add(0, 0, 1, 8'h00);
    for (int n = 0; n <= 8; n++)
      add(0, 0, 0, (n == 6) ? 8'hCC : ((n > 6) ? 8'h88 : 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      sw_0 = tbl[i].sw0;
      sw_1 = tbl[i].sw1;
      rst  = tbl[i].rst;
      tick();
      check("table", i, outs, tbl[i].exp);
    end

    // Bounce on ch1: low/high every 2 cycles for 20 cycles, then high.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      sw_1 = (n < 20) ? (((n / 2) % 2) == 1) : 1'b1;
      tick();
      check("bounce", n, outs, 8'h00);
    end

    // Long press then release on ch0.
    do_reset();
    sw_0 = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      tick();
      e = {(n >= 6 && n < 32), (n == 6), (n == 32), (n == 15), 4'b0000};
      check("long_rel", n, outs, e);
      if (n == 25) sw_0 = 1'b1;
    end

    // Release bounce while HELD: 2-cycle high glitch must not release.
    do_reset();
    sw_0  = 1'b0;
    longs = 0;
    for (int n = 0; n <= 30; n++) begin
      tick();
      if (key0_long) longs++;
      if (n == 6) check("rb_press", n, outs, 8'hC0);
      if (n >= 7) check("rb_hold", n, outs & 8'hEF, 8'h80);
      if (n == 9) sw_0 = 1'b1;
      if (n == 11) sw_0 = 1'b0;
    end
    check("rb_long_count", 0, 8'(longs), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

- Conditions the two active-low push-button inputs `sw_0` and `sw_1` for the pulse-divider control FSM that sits directly downstream.
- Each input is synchronised, debounced and converted into clean, active-high outputs: a debounced level, a one-cycle press strobe, a one-cycle release strobe and a one-cycle long-press strobe.
- The downstream FSM consumes `key0_press` as its start request and `key1_press` as its stop request, in place of raw inverted switch levels.

## Interface

Parameters:
- `DB_CYCLES`, 50000: stable-sample count required to accept a level change (1 ms at 50 MHz); legal range 2..2^`CNT_W`.
- `CNT_W`, 16: debounce counter width.
- `LONG_CYCLES`, 25000000: held-cycles count before the long-press strobe fires; legal range 2..2^`LONG_W`.
- `LONG_W`, 25: hold counter width.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` input 1: system clock.
- `rst` input 1: synchronous reset, active-high.
- `sw_0` input 1: raw button 0, asynchronous, low = pressed.
- `sw_1` input 1: raw button 1, asynchronous, low = pressed.
- `key0_level` output 1: debounced pressed state of button 0; reset 0.
- `key1_level` output 1: debounced pressed state of button 1; reset 0.
- `key0_press` output 1: one-cycle strobe on accepted press; reset 0.
- `key1_press` output 1: one-cycle strobe on accepted press; reset 0.
- `key0_release` output 1: one-cycle strobe on accepted release; reset 0.
- `key1_release` output 1: one-cycle strobe on accepted release; reset 0.
- `key0_long` output 1: one-cycle strobe when hold reaches `LONG_CYCLES`; reset 0.
- `key1_long` output 1: one-cycle strobe when hold reaches `LONG_CYCLES`; reset 0.

## Operation

The two channels are identical and fully independent.

Synchroniser:
- Two-flop synchroniser per input; both flops reset to 1 (released).
- `p = ~sync2` is the synchronised pressed indication.

FSM per channel:
- States: `IDLE`, `PRESS_WAIT`, `HELD`, `REL_WAIT`; reset state `IDLE`; debounce counter `cnt` and hold counter `hcnt` reset to 0.
- `IDLE`: if `p`=1, go to `PRESS_WAIT` with `cnt`=0.
- `PRESS_WAIT`:
  - `p`=0 returns to `IDLE`. This is bounce rejection; no strobe is issued.
  - Otherwise `cnt` increments.
  - When `cnt`==`DB_CYCLES`-1 and `p`=1, go to `HELD`, set `level`=1, pulse `press`, clear `hcnt`.
- `HELD`:
  - `hcnt` increments while below `LONG_CYCLES`-1.
  - On reaching `LONG_CYCLES`-1, pulse `long` once; `hcnt` then saturates, so there is no repeat.
  - `p`=0 goes to `REL_WAIT` with `cnt`=0.
- `REL_WAIT`:
  - `p`=1 returns to `HELD`. `hcnt` keeps its value; no strobe is issued.
  - Otherwise `cnt` increments.
  - When `cnt`==`DB_CYCLES`-1, go to `IDLE`, set `level`=0, pulse `release`.

Output rules:
- All outputs are registered.
- Each strobe is high for exactly one cycle per accepted event.
- `press` and `release` for the same channel are never high together.
- `long` for a channel never coincides with that channel's `press`.

Boundary and simultaneous cases:
- Simultaneous presses on both channels produce both press strobes in the same cycle. Arbitration belongs to the downstream FSM.
- Counters never wrap: `cnt` is cleared on every state entry, and `hcnt` saturates.
- Reset mid-operation (any state) returns the channel to `IDLE` on the next edge. All outputs go to 0 and no release strobe is generated.
- A button held through reset release is re-debounced from `IDLE` and produces a fresh `press` strobe.

## Timing

- Press latency:
  - `sw_x` low first sampled at edge E.
  - `p`=1 after E+1.
  - `PRESS_WAIT` entered at E+2.
  - `HELD` entered, with `press` and `level` visible, after edge E+2+`DB_CYCLES`.
- Release latency is the same: `DB_CYCLES`+2 edges.
- `long` fires `LONG_CYCLES`-1 edges after `HELD` entry, i.e. after edge E+1+`DB_CYCLES`+`LONG_CYCLES`.
- Any single-cycle glitch of `p` shorter than `DB_CYCLES` cycles produces no output change.

## Structure

- Shared package: the state enum (`IDLE`, `PRESS_WAIT`, `HELD`, `REL_WAIT`) and default constants for `DB_CYCLES` and `LONG_CYCLES`.
- One sub-module, `debounce_ch`: single-channel synchroniser, FSM and counters. It is instantiated twice in `key_debouncer`, with `sw_0` and `sw_1`.
- The top level contains only the instantiations and port mapping.

## Test plan

All scenarios use `DB_CYCLES`=4 and `LONG_CYCLES`=10.

1. Clean press: `sw_0` driven low at edge 0 and held. Required: `key0_press` high for exactly one cycle after edge 6; `key0_level`=1 thereafter; `key1_*` all 0.
2. Bounce rejection: `sw_1` toggles low/high every 2 cycles for 20 cycles, then settles high. Required: no `key1_*` strobes and `key1_level`=0 throughout.
3. Release and long press: press `sw_0` and hold 20 cycles after `HELD` entry, then release. Required: `key0_long` single pulse 9 edges after `HELD` entry; `key0_release` single pulse 6 edges after release; `key0_level` falls in the same cycle as the release strobe.
4. Release bounce: while `HELD`, drive `sw_0` high for 2 cycles, then low again. Required: state returns to `HELD`; no `key0_release` strobe; `key0_level` stays 1.
5. Simultaneous presses: `sw_0` and `sw_1` low on the same edge. Required: `key0_press` and `key1_press` high in the same cycle after edge 6.
6. Reset mid-operation: assert `rst` for 1 cycle while `key0` is in `HELD`, button still held. Required:
   - All outputs 0 on the edge after reset.
   - No `key0_release` strobe.
   - A fresh `key0_press` strobe 6 edges after reset deassertion, allowing for the synchroniser reset values.
